// File: rtl/vga_stream_if.sv
// Frame-buffer read port and video output bundle driven by vga_stream_gen.
interface vga_stream_if #(
   parameter int COLOR_W = 4,
   parameter int ADDR_W  = 19
);
   // pix_rd_en qualifies pixel_addr with no back-pressure: the buffer must
   // present the word on R_i/G_i/B_i exactly RD_LAT clocks after the strobe.
   logic [ADDR_W-1:0]  pixel_addr;
   logic               pix_rd_en;
   logic [COLOR_W-1:0] R_i, G_i, B_i;
   logic               h_synch, v_synch, de, frame_start;
   logic [COLOR_W-1:0] R_o, G_o, B_o;
   logic [10:0]        hcount, vcount;

   modport master (
      output pixel_addr, pix_rd_en, h_synch, v_synch, de, frame_start,
      output R_o, G_o, B_o, hcount, vcount,
      input  R_i, G_i, B_i
   );

   modport slave (
      input  pixel_addr, pix_rd_en, h_synch, v_synch, de, frame_start,
      input  R_o, G_o, B_o, hcount, vcount,
      output R_i, G_i, B_i
   );
endinterface

// File: rtl/vga_stream_gen.sv
// VGA timing generator with incremental frame-buffer addressing and read-latency compensation.
// Optional colour-bar test pattern: define VGA_STREAM_TESTPAT_EN (adds input test_mode).
module vga_stream_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int HS_POL   = 0,
   parameter int VS_POL   = 0,
   parameter int COLOR_W  = 4,
   parameter int ADDR_W   = 19,
   parameter int SCALE    = 0,
   parameter int RD_LAT   = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
`ifdef VGA_STREAM_TESTPAT_EN
   input  logic         test_mode,
`endif
   vga_stream_if.master vid
);
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC - 1;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC - 1;
   localparam int H_SRC    = H_ACTIVE >> SCALE;
   localparam int DLY      = RD_LAT + 1;
   localparam logic HS_ON  = (HS_POL != 0);
   localparam logic VS_ON  = (VS_POL != 0);

   if (SCALE > 0 && (((H_ACTIVE % (1 << SCALE)) != 0) || ((V_ACTIVE % (1 << SCALE)) != 0)))
   begin : g_bad_scale
      $error("vga_stream_gen: H_ACTIVE and V_ACTIVE must be divisible by 2**SCALE");
   end
   if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
      $error("vga_stream_gen: RD_LAT must be in 1..4");
   end

   logic [10:0]       h_cnt, v_cnt;
   logic [ADDR_W-1:0] line_base;
   logic              h_last, v_last, line_end, base_step;
   logic              live, active_raw, rd_ok, hs_raw, vs_raw, fs_raw;

   assign h_last    = (h_cnt == 11'(H_TOTAL - 1));
   assign v_last    = (v_cnt == 11'(V_TOTAL - 1));
   assign line_end  = (h_cnt == 11'(H_ACTIVE - 1)) && (v_cnt < 11'(V_ACTIVE));
   // Source line advances only when the replicated line index changes.
   assign base_step = ((v_cnt + 11'd1) >> SCALE) != (v_cnt >> SCALE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt     <= '0;
         v_cnt     <= '0;
         line_base <= '0;
      end else if (!en) begin
         h_cnt     <= '0;
         v_cnt     <= '0;
         line_base <= '0;
      end else begin
         if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? 11'd0 : v_cnt + 11'd1;
         end else begin
            h_cnt <= h_cnt + 11'd1;
         end
         if (h_last && v_last)
            line_base <= '0;
         else if (line_end && base_step)
            line_base <= line_base + ADDR_W'(H_SRC);
      end
   end

   // Reset gates the raw stage so nothing is fetched while rst_n is low.
   assign live       = en & rst_n;
   assign active_raw = live && (h_cnt < 11'(H_ACTIVE)) && (v_cnt < 11'(V_ACTIVE));
   assign hs_raw     = live && (h_cnt >= 11'(HS_START)) && (h_cnt <= 11'(HS_END));
   assign vs_raw     = live && (v_cnt >= 11'(VS_START)) && (v_cnt <= 11'(VS_END));
   assign fs_raw     = live && (h_cnt == 11'd0) && (v_cnt == 11'd0);

`ifdef VGA_STREAM_TESTPAT_EN
   assign rd_ok = active_raw & ~test_mode;
`else
   assign rd_ok = active_raw;
`endif

   assign vid.pix_rd_en  = rd_ok;
   assign vid.pixel_addr = rd_ok ? (line_base + ADDR_W'(h_cnt >> SCALE)) : '0;
   assign vid.hcount     = h_cnt;
   assign vid.vcount     = v_cnt;

   logic [DLY-1:0] de_p, hs_p, vs_p, fs_p;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         de_p <= '0;
         fs_p <= '0;
         hs_p <= {DLY{~HS_ON}};
         vs_p <= {DLY{~VS_ON}};
      end else begin
         de_p <= {de_p[DLY-2:0], active_raw};
         fs_p <= {fs_p[DLY-2:0], fs_raw};
         hs_p <= {hs_p[DLY-2:0], (hs_raw ? HS_ON : ~HS_ON)};
         vs_p <= {vs_p[DLY-2:0], (vs_raw ? VS_ON : ~VS_ON)};
      end
   end

`ifdef VGA_STREAM_TESTPAT_EN
   localparam int BAR_W = H_ACTIVE / 8;
   logic [2:0]          bar_raw;
   logic [DLY-1:0]      tp_p;
   logic [DLY-1:0][2:0] bar_p;
   logic [2:0]          bar_rgb;

   always_comb begin
      bar_raw = '0;
      for (int k = 1; k < 8; k++)
         if (h_cnt >= 11'(k * BAR_W)) bar_raw = 3'(k);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tp_p  <= '0;
         bar_p <= '0;
      end else begin
         tp_p  <= {tp_p[DLY-2:0], test_mode};
         bar_p <= {bar_p[DLY-2:0], bar_raw};
      end
   end

   // Bar order: white, yellow, cyan, green, magenta, red, blue, black ({R,G,B}).
   always_comb begin
      case (bar_p[RD_LAT-1])
         3'd0:    bar_rgb = 3'b111;
         3'd1:    bar_rgb = 3'b110;
         3'd2:    bar_rgb = 3'b011;
         3'd3:    bar_rgb = 3'b010;
         3'd4:    bar_rgb = 3'b101;
         3'd5:    bar_rgb = 3'b100;
         3'd6:    bar_rgb = 3'b001;
         default: bar_rgb = 3'b000;
      endcase
   end
`endif

   logic [COLOR_W-1:0] r_q, g_q, b_q;

   // Stage RD_LAT-1 travels with the word now arriving from the buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= '0;
         g_q <= '0;
         b_q <= '0;
      end else if (!de_p[RD_LAT-1]) begin
         r_q <= '0;
         g_q <= '0;
         b_q <= '0;
      end
`ifdef VGA_STREAM_TESTPAT_EN
      else if (tp_p[RD_LAT-1]) begin
         r_q <= {COLOR_W{bar_rgb[2]}};
         g_q <= {COLOR_W{bar_rgb[1]}};
         b_q <= {COLOR_W{bar_rgb[0]}};
      end
`endif
      else begin
         r_q <= vid.R_i;
         g_q <= vid.G_i;
         b_q <= vid.B_i;
      end
   end

   assign vid.de          = de_p[DLY-1];
   assign vid.frame_start = fs_p[DLY-1];
   assign vid.h_synch     = hs_p[DLY-1];
   assign vid.v_synch     = vs_p[DLY-1];
   assign vid.R_o         = r_q;
   assign vid.G_o         = g_q;
   assign vid.B_o         = b_q;
endmodule

// File: tb/tb_vga_stream_gen.sv
// Directed bench: instance A has default line timing with a short frame; instance B is
// a small 2x-scaled, RD_LAT=3, active-high-sync geometry. Both read a model RAM returning addr[11:0].
module tb_vga_stream_gen;
   logic clk = 1'b0;
   logic rst_n, en_a, en_b;
   int   n_pass = 0;
   int   n_total = 0;
   int   de_cnt, hs_cnt, vs_cnt, fs_cnt, blank_bad, de_first, de_last, hs_first, fs_first;
`ifdef VGA_STREAM_TESTPAT_EN
   logic tm_a;
`endif

   always #5 clk = ~clk;

   vga_stream_if #(.COLOR_W(4), .ADDR_W(19)) ifa ();
   vga_stream_if #(.COLOR_W(4), .ADDR_W(12)) ifb ();

   vga_stream_gen #(.V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en_a),
`ifdef VGA_STREAM_TESTPAT_EN
      .test_mode(tm_a),
`endif
      .vid(ifa)
   );

   vga_stream_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
      .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1), .VS_POL(1), .ADDR_W(12), .SCALE(1), .RD_LAT(3)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en_b),
`ifdef VGA_STREAM_TESTPAT_EN
      .test_mode(1'b0),
`endif
      .vid(ifb)
   );

   // Model RAMs: unread cycles return 0xFFF so blanking is observable.
   logic [11:0] ram_a_q, ram_b_q1, ram_b_q2, ram_b_q3;
   always @(posedge clk) ram_a_q <= ifa.pix_rd_en ? ifa.pixel_addr[11:0] : 12'hFFF;
   always @(posedge clk) begin
      ram_b_q1 <= ifb.pix_rd_en ? ifb.pixel_addr : 12'hFFF;
      ram_b_q2 <= ram_b_q1;
      ram_b_q3 <= ram_b_q2;
   end
   assign ifa.R_i = ram_a_q[11:8];
   assign ifa.G_i = ram_a_q[7:4];
   assign ifa.B_i = ram_a_q[3:0];
   assign ifb.R_i = ram_b_q3[11:8];
   assign ifb.G_i = ram_b_q3[7:4];
   assign ifb.B_i = ram_b_q3[3:0];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_a(input int h, input int v, input string tag);
      int n = 0;
      while (!(ifa.hcount == 11'(h) && ifa.vcount == 11'(v)) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " reached"}, 32'(n < 20000), 32'd1);
   endtask

   task automatic wait_b(input int h, input int v, input string tag);
      int n = 0;
      while (!(ifb.hcount == 11'(h) && ifb.vcount == 11'(v)) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " reached"}, 32'(n < 2000), 32'd1);
   endtask

   initial begin
      rst_n = 1'b0;
      en_a  = 1'b1;
      en_b  = 1'b1;
`ifdef VGA_STREAM_TESTPAT_EN
      tm_a  = 1'b0;
`endif
      tick(2);
      chk("rst hsync",  32'(ifa.h_synch), 32'd1);
      chk("rst vsync",  32'(ifa.v_synch), 32'd1);
      chk("rst de",     32'(ifa.de), 32'd0);
      chk("rst rgb",    32'({ifa.R_o, ifa.G_o, ifa.B_o}), 32'h000);
      chk("rst addr",   32'(ifa.pixel_addr), 32'd0);
      chk("rst rd_en",  32'(ifa.pix_rd_en), 32'd0);
      chk("rst fs",     32'(ifa.frame_start), 32'd0);
      chk("rst b hsync", 32'(ifb.h_synch), 32'd0);
      chk("rst b vsync", 32'(ifb.v_synch), 32'd0);

      rst_n = 1'b1;
      #1;
      chk("rel rd_en", 32'(ifa.pix_rd_en), 32'd1);
      chk("rel addr",  32'(ifa.pixel_addr), 32'd0);
      tick(1);
      chk("rel fs +1", 32'(ifa.frame_start), 32'd0);
      tick(1);
      chk("rel fs +2", 32'(ifa.frame_start), 32'd1);
      chk("rel de +2", 32'(ifa.de), 32'd1);
      chk("rel rgb px0", 32'({ifa.R_o, ifa.G_o, ifa.B_o}), 32'h000);
      tick(1);
      chk("rel fs +3", 32'(ifa.frame_start), 32'd0);
      chk("rel rgb px1", 32'({ifa.R_o, ifa.G_o, ifa.B_o}), 32'h001);

      // One line, observed from raw hcount=0 of line 1 through the 2-clock pipeline.
      wait_a(0, 1, "line1");
      de_cnt = 0; hs_cnt = 0; blank_bad = 0; de_first = -1; de_last = -1; hs_first = -1;
      for (int i = 0; i < 802; i++) begin
         if (i == 800) begin
            chk("line len hcount", 32'(ifa.hcount), 32'd0);
            chk("line len vcount", 32'(ifa.vcount), 32'd2);
         end
         if (i >= 2) begin
            if (ifa.de) begin
               de_cnt++;
               if (de_first < 0) de_first = i;
               de_last = i;
            end else if ({ifa.R_o, ifa.G_o, ifa.B_o} != 12'h000) begin
               blank_bad++;
            end
            if (!ifa.h_synch) begin
               hs_cnt++;
               if (hs_first < 0) hs_first = i;
            end
         end
         @(negedge clk);
      end
      chk("line de count", 32'(de_cnt), 32'd640);
      chk("line de first", 32'(de_first), 32'd2);
      chk("line de last",  32'(de_last), 32'd641);
      chk("line hs count", 32'(hs_cnt), 32'd96);
      chk("line hs first", 32'(hs_first), 32'd658);
      chk("line blanking", 32'(blank_bad), 32'd0);

      // One frame of 8 lines x 800 clocks.
      wait_a(0, 0, "frame");
      de_cnt = 0; vs_cnt = 0; fs_cnt = 0; fs_first = -1;
      for (int i = 0; i < 6402; i++) begin
         if (i >= 2) begin
            if (ifa.de) de_cnt++;
            if (!ifa.v_synch) vs_cnt++;
            if (ifa.frame_start) begin
               fs_cnt++;
               if (fs_first < 0) fs_first = i;
            end
         end
         @(negedge clk);
      end
      chk("frame de count", 32'(de_cnt), 32'd2560);
      chk("frame vs count", 32'(vs_cnt), 32'd1600);
      chk("frame fs count", 32'(fs_cnt), 32'd1);
      chk("frame fs first", 32'(fs_first), 32'd2);

      wait_a(639, 3, "last px a");
      chk("last px a addr",  32'(ifa.pixel_addr), 32'd2559);
      chk("last px a rd_en", 32'(ifa.pix_rd_en), 32'd1);
      tick(1);
      chk("past active rd_en", 32'(ifa.pix_rd_en), 32'd0);
      chk("past active addr",  32'(ifa.pixel_addr), 32'd0);

      // Enable drop mid-line, then restart.
      wait_a(100, 2, "en drop");
      en_a = 1'b0;
      #1;
      chk("en0 rd_en", 32'(ifa.pix_rd_en), 32'd0);
      chk("en0 addr",  32'(ifa.pixel_addr), 32'd0);
      tick(1);
      chk("en0 de draining", 32'(ifa.de), 32'd1);
      chk("en0 hcount +1",   32'(ifa.hcount), 32'd0);
      tick(1);
      chk("en0 de +2",   32'(ifa.de), 32'd0);
      chk("en0 rgb +2",  32'({ifa.R_o, ifa.G_o, ifa.B_o}), 32'h000);
      chk("en0 hsync +2", 32'(ifa.h_synch), 32'd1);
      tick(5);
      chk("en0 hold vcount", 32'(ifa.vcount), 32'd0);
      chk("en0 hold hcount", 32'(ifa.hcount), 32'd0);
      en_a = 1'b1;
      #1;
      chk("en1 rd_en", 32'(ifa.pix_rd_en), 32'd1);
      chk("en1 addr",  32'(ifa.pixel_addr), 32'd0);
      tick(1);
      chk("en1 fs +1", 32'(ifa.frame_start), 32'd0);
      tick(1);
      chk("en1 fs +2",   32'(ifa.frame_start), 32'd1);
      chk("en1 addr h2", 32'(ifa.pixel_addr), 32'd2);

`ifdef VGA_STREAM_TESTPAT_EN
      tm_a = 1'b1;
      wait_a(0, 1, "tp px0");
      chk("tp rd_en", 32'(ifa.pix_rd_en), 32'd0);
      tick(2);
      chk("tp px0 rgb", 32'({ifa.R_o, ifa.G_o, ifa.B_o}), 32'hFFF);
      wait_a(80, 1, "tp px80");
      tick(2);
      chk("tp px80 rgb", 32'({ifa.R_o, ifa.G_o, ifa.B_o}), 32'hFF0);
      wait_a(639, 1, "tp px639");
      tick(2);
      chk("tp px639 rgb", 32'({ifa.R_o, ifa.G_o, ifa.B_o}), 32'h000);
      tm_a = 1'b0;
`endif

      // Instance B: 4-clock output latency, 8x4 source replicated 2x2.
      wait_b(0, 0, "b line0");
      tick(3);
      chk("b de +3", 32'(ifb.de), 32'd0);
      tick(1);
      chk("b de +4",  32'(ifb.de), 32'd1);
      chk("b fs +4",  32'(ifb.frame_start), 32'd1);
      chk("b rgb px0", 32'({ifb.R_o, ifb.G_o, ifb.B_o}), 32'h000);
      tick(2);
      chk("b rgb px2", 32'({ifb.R_o, ifb.G_o, ifb.B_o}), 32'h001);
      wait_b(18, 0, "b hsync");
      tick(3);
      chk("b hsync +3", 32'(ifb.h_synch), 32'd0);
      tick(1);
      chk("b hsync +4", 32'(ifb.h_synch), 32'd1);
      wait_b(5, 0, "b l0 px5");
      chk("b l0 px5 addr", 32'(ifb.pixel_addr), 32'd2);
      wait_b(5, 1, "b l1 px5");
      chk("b l1 px5 addr", 32'(ifb.pixel_addr), 32'd2);
      wait_b(0, 5, "b l5 px0");
      chk("b l5 px0 addr", 32'(ifb.pixel_addr), 32'd16);
      tick(3);
      chk("b l5 px3 addr", 32'(ifb.pixel_addr), 32'd17);
      tick(1);
      chk("b l5 de",  32'(ifb.de), 32'd1);
      chk("b l5 rgb", 32'({ifb.R_o, ifb.G_o, ifb.B_o}), 32'h010);
      wait_b(15, 7, "b last px");
      chk("b last px addr",  32'(ifb.pixel_addr), 32'd31);
      chk("b last px rd_en", 32'(ifb.pix_rd_en), 32'd1);
      wait_b(0, 9, "b vsync");
      tick(3);
      chk("b vsync +3", 32'(ifb.v_synch), 32'd0);
      tick(1);
      chk("b vsync +4", 32'(ifb.v_synch), 32'd1);

      // Reset asserted while hsync is active on instance A.
      wait_a(700, 1, "midline rst");
      rst_n = 1'b0;
      tick(1);
      chk("mrst hsync",  32'(ifa.h_synch), 32'd1);
      chk("mrst vsync",  32'(ifa.v_synch), 32'd1);
      chk("mrst de",     32'(ifa.de), 32'd0);
      chk("mrst rgb",    32'({ifa.R_o, ifa.G_o, ifa.B_o}), 32'h000);
      chk("mrst addr",   32'(ifa.pixel_addr), 32'd0);
      chk("mrst rd_en",  32'(ifa.pix_rd_en), 32'd0);
      chk("mrst hcount", 32'(ifa.hcount), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/vga_stream_gen.md
Name: vga_stream_gen

Overview:
- Parametrised VGA timing and frame-buffer read generator; successor to my_vga_syn.
- Produces programmable H/V timing with selectable sync polarity.
- Generates dual-port-RAM read addresses with optional integer down-scaled source (pixel/line replication), compensates a configurable RAM read latency, and blanks colour outside the active area.
- Sits between vga_dpram and the VGA connector in the OV7670 pipeline.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active low)
VS_POL, 0, vsync active level
COLOR_W, 4, bits per colour channel
ADDR_W, 19, frame-buffer address width
SCALE, 0, log2 replication factor; source is (H_ACTIVE>>SCALE) x (V_ACTIVE>>SCALE)
RD_LAT, 1, frame-buffer read latency in clocks (1..4)

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable
pixel_addr  out  ADDR_W  frame-buffer read address
pix_rd_en  out  1  read strobe, high while address is valid
R_i, G_i, B_i  in  COLOR_W each  read data from buffer
h_synch, v_synch  out  1 each  sync outputs
de  out  1  display enable, aligned with R_o/G_o/B_o
R_o, G_o, B_o  out  COLOR_W each  pixel colour
frame_start  out  1  one-clock pulse with output pixel (0,0)
hcount, vcount  out  11 each  raw timing counters (pre-pipeline)

Behaviour:
- Counters:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
  - hcount runs 0..H_TOTAL-1 and wraps to 0.
  - vcount increments on each hcount wrap and wraps to 0 after V_TOTAL-1.
- Raw sync:
  - hsync is active for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vsync is active for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
  - Outputs drive HS_POL/VS_POL when active, inverted otherwise.
- Active area: hcount<H_ACTIVE and vcount<V_ACTIVE.
- Address generation, incremental with no multiplier:
  - pixel_addr = line_base + (hcount>>SCALE), issued in the same cycle as the raw counters.
  - At the end of active line v, line_base += (H_ACTIVE>>SCALE) only if ((v+1)>>SCALE) != (v>>SCALE).
  - line_base clears to 0 at vcount wrap.
  - Outside the active area, pixel_addr = 0 and pix_rd_en = 0.
- Latency:
  - de, h_synch, v_synch, frame_start and colour are all delayed to RD_LAT+1 clocks after the raw counters.
  - The sync pipeline is RD_LAT+1 stages; colour is registered once when data arrives.
- Blanking: R_o/G_o/B_o = 0 whenever the delayed de is 0; otherwise they are the registered R_i/G_i/B_i.
- Reset (async, rst_n=0):
  - Counters, line_base and pixel_addr = 0; pix_rd_en, de and frame_start = 0.
  - Colour outputs = 0.
  - h_synch = ~HS_POL, v_synch = ~VS_POL.
  - All pipeline stages are cleared to these inactive values.
- en=0:
  - Counters and line_base are synchronously forced to 0 and pix_rd_en = 0.
  - The pipeline continues flushing inactive values, so outputs go inactive after RD_LAT+1 clocks.
  - Deassertion mid-frame is legal.
  - Re-enabling starts cleanly at (0,0), with frame_start RD_LAT+1 clocks later.
- Parameter guard: SCALE>0 requires H_ACTIVE and V_ACTIVE to be divisible by 2^SCALE. An elaboration-time check reports violations.

Optional Feature:
- Macro: VGA_STREAM_TESTPAT_EN.
- When defined:
  - Adds input test_mode (1 bit).
  - While test_mode=1, active pixels show 8 vertical colour bars of width H_ACTIVE/8, in order white, yellow, cyan, green, magenta, red, blue, black (all-ones/zero per channel).
  - R_i/G_i/B_i are ignored and pix_rd_en is forced 0.
  - Timing and latency are unchanged.
- When undefined: no port, no logic; behaviour is exactly as above.

Test Plan:
- Reset/hold: rst_n=0 mid-line -> next clock h_synch=1, v_synch=1, de=0, RGB=0, pixel_addr=0; after release at en=1, frame_start pulses exactly 2 clocks later (RD_LAT=1).
- Line timing (defaults): count one line -> 800 clocks per line; h_synch low for 96 clocks starting 656+2 clocks after hcount=0; de high for 640 consecutive clocks.
- Frame timing: count v_synch -> low for 2 lines (1600 clocks) per 420000-clock frame; exactly one frame_start per frame.
- Scaling: SCALE=1:
  - hcount=3, vcount=5 -> pixel_addr=2*320+1=641.
  - Last active pixel -> 76799.
  - Lines 0 and 1 -> identical address sequence.
  - SCALE=0, last pixel -> 307199.
- Latency: RD_LAT=3 with model RAM returning data=addr[11:0] -> R_o/G_o/B_o at first de clock equal 0x000; second de clock equals 0x001; de coincides with matching data; sync shifted to 4 clocks.
- Enable and test pattern:
  - en dropped at vcount=100 -> outputs inactive within 2 clocks; re-enable -> frame_start after 2 clocks and pixel_addr restarts at 0.
  - With VGA_STREAM_TESTPAT_EN and test_mode=1 -> pixel 0 = F/F/F, pixel 80 = F/F/0, pixel 639 = 0/0/0.
